// File: rtl/booth_mul_arbiter_if.sv
// Requester- and multiplier-side signals of the shared Booth multiplier arbiter.
// The slave side is the arbiter; the master side is the requesters plus the multiplier.
interface booth_mul_arbiter_if;
  logic        req0, req1;
  logic [9:0]  a0, a1, b0, b1;
  logic        az0, az1, bz0, bz1;
  logic        gnt0, gnt1;
  logic [9:0]  mul_a, mul_b;
  logic        mul_az, mul_bz;
  logic [23:0] mul_s;
  logic [23:0] res0, res1;
  logic        done0, done1;
  logic        busy;
  logic [3:0]  inflight;

  modport slave (
    input  req0, req1, a0, a1, b0, b1, az0, az1, bz0, bz1, mul_s,
    output gnt0, gnt1, mul_a, mul_b, mul_az, mul_bz, res0, res1, done0, done1, busy, inflight
  );

  modport master (
    output req0, req1, a0, a1, b0, b1, az0, az1, bz0, bz1, mul_s,
    input  gnt0, gnt1, mul_a, mul_b, mul_az, mul_bz, res0, res1, done0, done1, busy, inflight
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Two-port arbiter for a shared LAT-deep pipelined significand multiplier; a valid/tag
// shift register follows each issued operation so its product returns to the issuing port.
module booth_mul_arbiter #(
  parameter int unsigned LAT       = 8,
  parameter bit          FIXED_PRI = 1'b0
) (
  input logic                CLK,
  input logic                RST,
  booth_mul_arbiter_if.slave bus
);

  logic           last_q;
  logic           gnt0, gnt1, gnt_any;
  logic [LAT-1:0] vld_q, tag_q;
  logic           retire, rtag;
  logic [23:0]    res0_q, res1_q;
  logic           done0_q, done1_q;
  logic [3:0]     inflight_q, inflight_d;

  // last_q = 1 means port 1 won most recently, so port 0 wins the next contention.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (bus.req0 && bus.req1) begin
      if (FIXED_PRI || last_q) gnt0 = 1'b1;
      else                     gnt1 = 1'b1;
    end else begin
      gnt0 = bus.req0;
      gnt1 = bus.req1;
    end
  end

  assign gnt_any  = gnt0 | gnt1;
  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;

  always_comb begin
    bus.mul_a  = '0;
    bus.mul_b  = '0;
    bus.mul_az = 1'b0;
    bus.mul_bz = 1'b0;
    if (gnt0) begin
      bus.mul_a  = bus.a0;
      bus.mul_b  = bus.b0;
      bus.mul_az = bus.az0;
      bus.mul_bz = bus.bz0;
    end else if (gnt1) begin
      bus.mul_a  = bus.a1;
      bus.mul_b  = bus.b1;
      bus.mul_az = bus.az1;
      bus.mul_bz = bus.bz1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_q <= 1'b1;
    end else if (gnt_any) begin
      last_q <= gnt1;
    end
  end

  // The last stage lines up with mul_s for the operation it tracks.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= {vld_q[LAT-2:0], gnt_any};
      tag_q <= {tag_q[LAT-2:0], gnt1};
    end
  end

  assign retire = vld_q[LAT-1];
  assign rtag   = tag_q[LAT-1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      res0_q  <= '0;
      res1_q  <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      done0_q <= retire & ~rtag;
      done1_q <= retire & rtag;
      if (retire && !rtag) res0_q <= bus.mul_s;
      if (retire && rtag)  res1_q <= bus.mul_s;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({gnt_any, retire})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) inflight_q <= '0;
    else      inflight_q <= inflight_d;
  end

  assign bus.res0     = res0_q;
  assign bus.res1     = res1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.inflight = inflight_q;
  assign bus.busy     = (inflight_q != 4'd0);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with the same directed stimulus and
// checks both against an event-scheduled model of grants and returning products.
module tb_booth_mul_arbiter;
  localparam int LAT = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic       rq0, rq1;
  logic [9:0] sa0, sa1, sb0, sb1;
  logic       saz0, saz1, sbz0, sbz1;

  booth_mul_arbiter_if bus_rr ();
  booth_mul_arbiter_if bus_fp ();

  assign bus_rr.req0 = rq0;  assign bus_fp.req0 = rq0;
  assign bus_rr.req1 = rq1;  assign bus_fp.req1 = rq1;
  assign bus_rr.a0   = sa0;  assign bus_fp.a0   = sa0;
  assign bus_rr.a1   = sa1;  assign bus_fp.a1   = sa1;
  assign bus_rr.b0   = sb0;  assign bus_fp.b0   = sb0;
  assign bus_rr.b1   = sb1;  assign bus_fp.b1   = sb1;
  assign bus_rr.az0  = saz0; assign bus_fp.az0  = saz0;
  assign bus_rr.az1  = saz1; assign bus_fp.az1  = saz1;
  assign bus_rr.bz0  = sbz0; assign bus_fp.bz0  = sbz0;
  assign bus_rr.bz1  = sbz1; assign bus_fp.bz1  = sbz1;

  booth_mul_arbiter #(.LAT(LAT), .FIXED_PRI(1'b0)) u_rr (.CLK(CLK), .RST(RST), .bus(bus_rr.slave));
  booth_mul_arbiter #(.LAT(LAT), .FIXED_PRI(1'b1)) u_fp (.CLK(CLK), .RST(RST), .bus(bus_fp.slave));

  // Multiplier stand-ins: operands captured at the grant edge, product out LAT-1 edges later.
  logic [23:0] pipe_rr [LAT];
  logic [23:0] pipe_fp [LAT];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < LAT; i++) pipe_rr[i] <= '0;
    end else begin
      pipe_rr[0] <= 24'({bus_rr.mul_az, bus_rr.mul_a}) * 24'({bus_rr.mul_bz, bus_rr.mul_b});
      for (int i = 1; i < LAT; i++) pipe_rr[i] <= pipe_rr[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < LAT; i++) pipe_fp[i] <= '0;
    end else begin
      pipe_fp[0] <= 24'({bus_fp.mul_az, bus_fp.mul_a}) * 24'({bus_fp.mul_bz, bus_fp.mul_b});
      for (int i = 1; i < LAT; i++) pipe_fp[i] <= pipe_fp[i-1];
    end
  end

  assign bus_rr.mul_s = pipe_rr[LAT-1];
  assign bus_fp.mul_s = pipe_fp[LAT-1];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
  endtask

  // Model: per DUT (0 = round-robin, 1 = fixed priority) a schedule of product returns
  // indexed by edge number; a grant at edge n returns at edge n+LAT.
  logic        mlast [2];
  int          minfl [2];
  logic [23:0] mres  [2][2];
  logic        mdone [2][2];
  logic        sv    [2][64];
  logic        sp    [2][64];
  logic [23:0] sd    [2][64];
  int          edge_n = 0;

  task automatic model_clear(input int m);
    mlast[m] = 1'b1;
    minfl[m] = 0;
    for (int p = 0; p < 2; p++) begin
      mres[m][p]  = '0;
      mdone[m][p] = 1'b0;
    end
    for (int s = 0; s < 64; s++) sv[m][s] = 1'b0;
  endtask

  task automatic check_dut(input int m, input string nm, input logic g0, input logic g1,
                           input logic [9:0] ma, input logic [9:0] mb, input logic maz,
                           input logic mbz, input logic d0, input logic d1,
                           input logic [23:0] r0, input logic [23:0] r1,
                           input logic [3:0] inf, input logic bsy);
    logic       eg0, eg1, eaz, ebz;
    logic [9:0] ea, eb;
    int         s;
    if (!RST) model_clear(m);
    if (rq0 && rq1) begin
      eg0 = (m == 1) || mlast[m];
      eg1 = !eg0;
    end else begin
      eg0 = rq0;
      eg1 = rq1;
    end
    ea  = eg0 ? sa0  : (eg1 ? sa1  : 10'd0);
    eb  = eg0 ? sb0  : (eg1 ? sb1  : 10'd0);
    eaz = eg0 ? saz0 : (eg1 ? saz1 : 1'b0);
    ebz = eg0 ? sbz0 : (eg1 ? sbz1 : 1'b0);
    chk({nm, ".gnt0"}, 32'(g0), 32'(eg0));
    chk({nm, ".gnt1"}, 32'(g1), 32'(eg1));
    chk({nm, ".mul_ops"}, 32'({maz, ma, mbz, mb}), 32'({eaz, ea, ebz, eb}));
    chk({nm, ".done0"}, 32'(d0), 32'(mdone[m][0]));
    chk({nm, ".done1"}, 32'(d1), 32'(mdone[m][1]));
    chk({nm, ".res0"}, 32'(r0), 32'(mres[m][0]));
    chk({nm, ".res1"}, 32'(r1), 32'(mres[m][1]));
    chk({nm, ".inflight"}, 32'(inf), 32'(minfl[m]));
    chk({nm, ".busy"}, 32'(bsy), 32'(minfl[m] != 0));
    if (RST) begin
      s = edge_n % 64;
      mdone[m][0] = 1'b0;
      mdone[m][1] = 1'b0;
      if (sv[m][s]) begin
        mdone[m][sp[m][s]] = 1'b1;
        mres[m][sp[m][s]]  = sd[m][s];
        minfl[m]--;
        sv[m][s] = 1'b0;
      end
      if (eg0 || eg1) begin
        s = (edge_n + LAT) % 64;
        sv[m][s] = 1'b1;
        sp[m][s] = eg1;
        sd[m][s] = 24'({eaz, ea}) * 24'({ebz, eb});
        minfl[m]++;
        mlast[m] = eg1;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      check_dut(0, "rr", bus_rr.gnt0, bus_rr.gnt1, bus_rr.mul_a, bus_rr.mul_b, bus_rr.mul_az,
                bus_rr.mul_bz, bus_rr.done0, bus_rr.done1, bus_rr.res0, bus_rr.res1,
                bus_rr.inflight, bus_rr.busy);
      check_dut(1, "fp", bus_fp.gnt0, bus_fp.gnt1, bus_fp.mul_a, bus_fp.mul_b, bus_fp.mul_az,
                bus_fp.mul_bz, bus_fp.done0, bus_fp.done1, bus_fp.res0, bus_fp.res1,
                bus_fp.inflight, bus_fp.busy);
      edge_n = edge_n + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    step(1);
    RST = 1'b0;
    step(2);
    RST = 1'b1;
  endtask

  task automatic wait_done(input int port, output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if ((port == 0) ? bus_rr.done0 : bus_rr.done1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) timeout($sformatf("wait_done%0d", port));
  endtask

  int         g, at, mx, cnt, nd;
  logic [5:0] order;

  initial begin
    rq0 = 1'b0; rq1 = 1'b0;
    sa0 = '0; sa1 = '0; sb0 = '0; sb1 = '0;
    saz0 = 1'b0; saz1 = 1'b0; sbz0 = 1'b0; sbz1 = 1'b0;
    step(2);
    RST = 1'b1;
    step(1);

    // Single op: 1.0 x 1.0 on port 0.
    saz0 = 1'b1; sa0 = 10'd0; sbz0 = 1'b1; sb0 = 10'd0; rq0 = 1'b1;
    g = cyc + 1;
    step(1);
    rq0 = 1'b0;
    @(negedge CLK);
    chk("single.inflight_after_grant", 32'(bus_rr.inflight), 32'd1);
    wait_done(0, at);
    chk("single.latency", 32'(at - g), 32'd8);
    chk("single.res0", 32'(bus_rr.res0), 32'h100000);
    chk("single.inflight_at_done", 32'(bus_rr.inflight), 32'd0);

    // Contention: port 0 2047x2047, port 1 1.0x1.0, six cycles.
    do_reset();
    sa0 = 10'h3FF; saz0 = 1'b1; sb0 = 10'h3FF; sbz0 = 1'b1;
    sa1 = 10'h000; saz1 = 1'b1; sb1 = 10'h000; sbz1 = 1'b1;
    rq0 = 1'b1; rq1 = 1'b1;
    order = '0; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      order[i] = bus_rr.gnt1;
      cnt += int'(bus_fp.gnt1);
      step(1);
    end
    rq0 = 1'b0; rq1 = 1'b0;
    chk("contend.rr_order", 32'(order), 32'h2A);
    chk("contend.fp_gnt1_count", 32'(cnt), 32'd0);
    step(12);
    chk("contend.res0", 32'(bus_rr.res0), 32'h3FF001);
    chk("contend.res1", 32'(bus_rr.res1), 32'h100000);

    // Streaming: port 0 for 12 consecutive cycles.
    do_reset();
    saz0 = 1'b1; sa0 = 10'h200; sbz0 = 1'b1; sb0 = 10'h001;
    rq0 = 1'b1; mx = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (int'(bus_rr.inflight) > mx) mx = int'(bus_rr.inflight);
      step(1);
    end
    rq0 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      if (int'(bus_rr.inflight) > mx) mx = int'(bus_rr.inflight);
      step(1);
    end
    chk("stream.max_inflight", 32'(mx), 32'd8);
    chk("stream.inflight_end", 32'(bus_rr.inflight), 32'd0);
    chk("stream.busy_end", 32'(bus_rr.busy), 32'd0);

    // Fixed priority: both request 4 cycles, then port 1 alone.
    do_reset();
    sa1 = 10'h000; saz1 = 1'b1; sb1 = 10'h000; sbz1 = 1'b1;
    rq0 = 1'b1; rq1 = 1'b1; cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      cnt += int'(bus_fp.gnt1);
      step(1);
    end
    rq0 = 1'b0;
    @(negedge CLK);
    chk("fixed.gnt1_after_drop", 32'(bus_fp.gnt1), 32'd1);
    step(1);
    rq1 = 1'b0;
    chk("fixed.gnt1_count_contended", 32'(cnt), 32'd0);
    step(12);

    // Zero operand A on port 1.
    saz1 = 1'b0; sa1 = 10'd0; sbz1 = 1'b1; sb1 = 10'h155; rq1 = 1'b1;
    step(1);
    rq1 = 1'b0;
    wait_done(1, at);
    chk("zero.res1", 32'(bus_rr.res1), 32'd0);
    step(2);

    // Reset mid-flight.
    saz0 = 1'b1; sa0 = 10'h0AA; sbz0 = 1'b1; sb0 = 10'h055;
    rq0 = 1'b1;
    step(3);
    rq0 = 1'b0;
    step(2);
    RST = 1'b0;
    #1;
    chk("rst.inflight", 32'(bus_rr.inflight), 32'd0);
    chk("rst.busy", 32'(bus_rr.busy), 32'd0);
    chk("rst.done", 32'({bus_rr.done0, bus_rr.done1}), 32'd0);
    chk("rst.res0", 32'(bus_rr.res0), 32'd0);
    chk("rst.res1", 32'(bus_rr.res1), 32'd0);
    step(2);
    RST = 1'b1;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      nd += int'(bus_rr.done0) + int'(bus_rr.done1) + int'(bus_fp.done0) + int'(bus_fp.done1);
      step(1);
    end
    chk("rst.no_done_after_release", 32'(nd), 32'd0);
    rq0 = 1'b1;
    g = cyc + 1;
    step(1);
    rq0 = 1'b0;
    wait_done(0, at);
    chk("rst.new_latency", 32'(at - g), 32'd8);
    chk("rst.new_res0", 32'(bus_rr.res0), 32'h143472);
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Two-port round-robin arbiter and sequencer for the shared 8-cycle pipelined Booth significand multiplier. Two floating-point requesters each present 11-bit significands (hidden bit plus 10-bit fraction). The arbiter grants at most one operation per cycle, drives the multiplier operand inputs, and tracks each issued operation's owner through a valid/tag shift register aligned to the multiplier latency. It returns each product to the issuing port with a one-cycle done pulse. It sits between the FP multiply front-ends and the multiplier instance.

## Interface
- LAT, 8, multiplier latency in edges from operand capture to product valid. Must equal the multiplier pipeline depth.
- FIXED_PRI, 0, 0 = round-robin; 1 = port 0 always wins.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  operation request; held with operands until granted.
- a0 / a1  in  10  fraction of operand A.
- az0 / az1  in  1  hidden bit of operand A.
- b0 / b1  in  10  fraction of operand B.
- bz0 / bz1  in  1  hidden bit of operand B.
- gnt0 / gnt1  out  1  combinational grant; the operation issues on the rising edge where req and gnt are both high.
- mul_a, mul_b  out  10  operands to the multiplier.
- mul_az, mul_bz  out  1  hidden bits to the multiplier.
- mul_s  in  24  product from the multiplier.
- res0 / res1  out  24  registered product for each port; holds its last value.
- done0 / done1  out  1  one-cycle pulse; the matching res is valid in that cycle.
- busy  out  1  high while any issued operation is in flight.
- inflight  out  4  count of issued operations whose done has not yet fired (0..LAT).

## Operation
- **Grant logic (combinational)**
  - Exactly one or zero grants per cycle; never both.
  - Only one request high: that port is granted.
  - Both requests high, round-robin: grant the port not granted most recently, as recorded by the `last` pointer.
  - Both requests high, FIXED_PRI=1: port 0 is granted.
- **Pointer update**
  - `last` updates only on an edge where a grant occurs.
  - Reset value of `last` is 1, so port 0 wins the first contention.
- **Operand mux**
  - mul_* carry the granted port's operands.
  - With no grant, mul_* are driven to 0; the resulting pipeline slot is tagged invalid.
- **Tracking shift register**
  - LAT stages of {valid, tag}; all stages shift every edge.
  - Stage 0 loads {grant_any, granted_port} on each edge.
  - Stage LAT-1 is aligned with mul_s.
- **Result routing**
  - On each edge, if stage LAT-1 is valid: res<tag> <= mul_s, done<tag> <= 1, the other port's done <= 0.
  - Otherwise both done <= 0.
  - The res of the non-addressed port holds its value.
- **Counters**
  - inflight: +1 on a grant edge, −1 on an edge that sets a done.
  - A simultaneous grant and done on the same edge leaves inflight unchanged.
  - busy = (inflight != 0).
- **Arithmetic**
  - Product = unsigned {az,a} × {bz,b}: 22 significant bits, zero-extended in 24.
  - The arbiter does not modify mul_s.
- **No backpressure**
  - Ports must accept done/res in the cycle presented.
  - A full pipeline (inflight = LAT) does not block grants, because the pipeline retires one slot per edge.
- **Reset**
  - Outputs reset to: gnt (combinational), res0 = res1 = 0, done0 = done1 = 0, inflight = 0, busy = 0, all tracking stages invalid.
  - The multiplier shares RST, so any in-flight operations are discarded and never produce done.

## Timing
- Grant edge E0: operands are captured by the multiplier, and stage 0 is loaded.
- mul_s is valid for the operation after edge E(LAT−1) = E7.
- res/done are registered at E8, so done is high in the cycle after E8.
- Throughput: one operation per cycle, total across both ports.
- Contention for N cycles alternates grants 0,1,0,1…
- A request deasserted before its grant edge issues nothing.
- Requesters change operands only after their grant edge.
- Reset asserted mid-flight: all outputs clear asynchronously. After release, the first done appears only for operations granted after release.

## Test plan
- **Single op, latency.** Port 0 only: az0=1, a0=0, bz0=1, b0=0, req0 for one grant. Expect done0 after E8 with res0=0x100000, done1 never asserted, inflight 1→0.
- **Contention.** Both ports request continuously for 6 cycles: port 0 with 2047×2047 (az=1, a=0x3FF, bz=1, b=0x3FF), port 1 with 1.0×1.0. Expect grants in order 0,1,0,1,0,1 and done pulses in the same order, 8 edges later. Expect res0=0x3FF001 and res1=0x100000.
- **Streaming.** Port 0 requests for 12 consecutive cycles. Expect inflight to reach 8 and stay at 8 while done and grant coincide, then a done every cycle until inflight=0 and busy=0.
- **Fixed priority.** With FIXED_PRI=1 and both ports requesting for 4 cycles, gnt1 stays low; when req0 drops, port 1 is granted on the next edge.
- **Zero operands.** az1=0, a1=0 with any B. Expect done1 with res1=0.
- **Reset mid-flight.** Issue 3 operations, then assert RST for 2 cycles before any done. Expect all outputs to be 0 immediately and no done within 10 cycles after release. A new request then completes normally with 8-edge latency.
